// File: rtl/fp32_booth_multiplier.sv
// fp32_booth_multiplier: sequential IEEE-754 single-precision multiplier
// using a radix-4 Booth significand datapath, flush-to-zero, round-nearest-even.
module fp32_booth_multiplier #(
   parameter int ITERS = 13
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] multiplicand,
   input  logic [31:0] multiplier,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] product
);
   typedef enum logic [1:0] {IDLE, ITER, ROUND, DONE} state_t;
   state_t state, state_nxt;
   logic [31:0] a, b;
   logic [3:0]  cnt;
   logic [49:0] acc, acc_sum;
   logic [25:0] m, pp, a1, a2;
   logic        prev;
   logic [2:0]  t;
   logic [47:0] mag;
   logic [9:0]  e0, e1;
   logic [22:0] frac;
   logic [23:0] sig;
   logic        hi, g, r, s, up, sgn;
   logic        zero_a, zero_b, inf_a, inf_b, nan_any, inf_any, zero_any;
   logic [31:0] res;

   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= state_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  state_nxt = in_valid ? ITER : IDLE;
         ITER:  state_nxt = (cnt == 4'(ITERS - 1)) ? ROUND : ITER;
         ROUND: state_nxt = DONE;
         DONE:  state_nxt = (out_valid && out_ready) ? IDLE : DONE;
      endcase
   end

   always_comb in_ready = (state == IDLE);

   // Booth digit from {m[1:0], prev}: 0 for 000/111, +-1 and +-2 otherwise
   assign t = {m[1:0], prev};
   assign a1 = {2'b00, |a[30:23], a[22:0]};
   assign a2 = {1'b0, |a[30:23], a[22:0], 1'b0};
   assign pp = (t == 3'b001 || t == 3'b010) ? a1 :
               (t == 3'b011) ? a2 :
               (t == 3'b100) ? -a2 :
               (t == 3'b101 || t == 3'b110) ? -a1 : '0;
   assign acc_sum = acc + {pp[25], pp, 23'b0};

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         a    <= '0;
         b    <= '0;
         m    <= '0;
         prev <= 1'b0;
         acc  <= '0;
         cnt  <= '0;
      end else if (state == IDLE && in_valid) begin
         a    <= multiplicand;
         b    <= multiplier;
         m    <= {2'b00, |multiplier[30:23], multiplier[22:0]};
         prev <= 1'b0;
         acc  <= '0;
         cnt  <= '0;
      end else if (state == ITER) begin
         acc  <= $signed(acc_sum) >>> 2;
         m    <= {acc_sum[1:0], m[25:2]};
         prev <= m[1];
         cnt  <= cnt + 4'd1;
      end

   // acc/m together hold product * 2^23 once all digits are retired
   assign mag = {acc[44:0], m[25:23]};
   assign sgn = a[31] ^ b[31];
   assign e0  = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
   assign hi  = mag[47];
   assign frac = hi ? mag[46:24] : mag[45:23];
   assign g   = hi ? mag[23] : mag[22];
   assign r   = hi ? mag[22] : mag[21];
   assign s   = (hi ? |mag[21:0] : |mag[20:0]) | |m[22:0];
   assign up  = g & (r | s | frac[0]);
   assign sig = {1'b0, frac} + {23'b0, up};
   assign e1  = e0 + {9'b0, hi} + {9'b0, sig[23]};

   assign zero_a   = (a[30:23] == 8'h00);
   assign zero_b   = (b[30:23] == 8'h00);
   assign inf_a    = (a[30:23] == 8'hFF) && (a[22:0] == '0);
   assign inf_b    = (b[30:23] == 8'hFF) && (b[22:0] == '0);
   assign inf_any  = inf_a | inf_b;
   assign zero_any = zero_a | zero_b;
   assign nan_any  = ((a[30:23] == 8'hFF) && (a[22:0] != '0)) ||
                     ((b[30:23] == 8'hFF) && (b[22:0] != '0)) || (inf_any && zero_any);
   assign res = nan_any ? 32'h7FC00000 :
                inf_any ? {sgn, 8'hFF, 23'b0} :
                zero_any ? {sgn, 31'b0} :
                ($signed(e1) >= 10'sd255) ? {sgn, 8'hFF, 23'b0} :
                ($signed(e1) <= 10'sd0) ? {sgn, 31'b0} : {sgn, e1[7:0], sig[22:0]};

   // out_valid follows DONE by one edge, giving a uniform 15-edge latency
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         out_valid <= 1'b0;
         product   <= '0;
      end else begin
         out_valid <= (state == DONE) && !(out_valid && out_ready);
         if (state == ROUND) product <= res;
      end
endmodule

// File: tb/tb_fp32_booth_multiplier.sv
// tb_fp32_booth_multiplier: randomized scoreboard bench with an arithmetic
// reference model, directed corner vectors, backpressure and mid-op reset.
module tb_fp32_booth_multiplier;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] multiplicand = '0;
   logic [31:0] multiplier = '0;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] product;
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          bp_mode = 0;
   logic        ov_q = 1'b0;
   logic [31:0] exp_q[$];
   int          lat_q[$];

   fp32_booth_multiplier dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .multiplicand(multiplicand), .multiplier(multiplier),
      .out_valid(out_valid), .out_ready(out_ready), .product(product)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s", name);
   endtask

   function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y);
      logic s;
      int ea, eb, e, sh;
      longint p, q, rem, half;
      s  = x[31] ^ y[31];
      ea = int'(x[30:23]);
      eb = int'(y[30:23]);
      if ((ea == 255 && x[22:0] != 0) || (eb == 255 && y[22:0] != 0)) return 32'h7FC00000;
      if ((ea == 255 || eb == 255) && (ea == 0 || eb == 0)) return 32'h7FC00000;
      if (ea == 255 || eb == 255) return {s, 8'hFF, 23'h0};
      if (ea == 0 || eb == 0) return {s, 31'h0};
      p  = longint'({1'b1, x[22:0]}) * longint'({1'b1, y[22:0]});
      e  = ea + eb - 127;
      sh = (p >= (64'sd1 <<< 47)) ? 24 : 23;
      e += sh - 23;
      q    = p >>> sh;
      rem  = p - (q <<< sh);
      half = 64'sd1 <<< (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'sd1 <<< 24)) begin
         q = q >>> 1;
         e++;
      end
      if (e >= 255) return {s, 8'hFF, 23'h0};
      if (e <= 0) return {s, 31'h0};
      return {s, 8'(e), 23'(q)};
   endfunction

   function automatic logic [31:0] rand_op();
      int k;
      logic [31:0] v;
      k = $urandom_range(0, 9);
      v = $urandom;
      if (k == 0) v[30:23] = 8'h00;
      else if (k == 1) begin
         v[30:23] = 8'hFF;
         if ($urandom_range(0, 1) == 0) v[22:0] = '0;
      end else if (k < 7) v[30:23] = 8'($urandom_range(64, 190));
      return v;
   endfunction

   // out_ready: 0 = always ready, 1 = random stalls, 2 = held low
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = (bp_mode == 1) ? ($urandom_range(0, 3) != 0) : (bp_mode == 0);
      end
   end

   always @(negedge clk) begin
      if (rst && out_valid && !ov_q) begin
         if (lat_q.size() == 0) fail_now("spurious_out_valid");
         else chk("latency", 32'(cyc - lat_q.pop_front()), 32'd15);
      end
      if (rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) fail_now("unexpected_product");
         else chk("product", product, exp_q.pop_front());
      end
      ov_q = out_valid;
   end

   task automatic issue(input logic [31:0] x, input logic [31:0] y);
      int w = 0;
      @(negedge clk);
      while (!in_ready && w < 300) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) begin
         fail_now("in_ready_timeout");
         return;
      end
      multiplicand = x;
      multiplier   = y;
      in_valid     = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      exp_q.push_back(model(x, y));
      lat_q.push_back(cyc);
      multiplicand = $urandom;
      multiplier   = $urandom;
   endtask

   task automatic drain();
      int w = 0;
      while (exp_q.size() != 0 && w < 500) begin
         @(negedge clk);
         w++;
      end
      if (exp_q.size() != 0) fail_now("drain_timeout");
   endtask

   initial begin
      logic [31:0] held;
      int w;
      #2;
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_product", product, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      issue(32'h3FC00000, 32'h40000000);
      chk("model_1p5x2", model(32'h3FC00000, 32'h40000000), 32'h40400000);
      issue(32'hC0400000, 32'h3F000000);
      issue(32'h3F800001, 32'h3F800001);
      issue(32'h7F800000, 32'h00000000);
      issue(32'h7F000000, 32'h7F000000);
      issue(32'h00800000, 32'h00800000);
      issue(32'h80000000, 32'h3F800000);
      issue(32'h7FC00001, 32'h3F800000);
      issue(32'hFF800000, 32'h40000000);
      issue(32'h3FFFFFFF, 32'h3FFFFFFF);
      drain();
      // backpressure: product held, in_valid ignored while DONE
      bp_mode = 2;
      issue(32'h40A00000, 32'hC1200000);
      w = 0;
      while (!out_valid && w < 40) begin
         @(negedge clk);
         w++;
      end
      if (!out_valid) fail_now("bp_out_valid_timeout");
      held = product;
      chk("bp_product_value", held, 32'hC2480000);
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         multiplicand = $urandom;
         multiplier = $urandom;
         @(negedge clk);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_product_stable", product, held);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      bp_mode = 0;
      w = 0;
      while (out_valid && w < 5) begin
         @(negedge clk);
         w++;
      end
      chk("bp_released_out_valid", 32'(out_valid), 32'd0);
      chk("bp_released_in_ready", 32'(in_ready), 32'd1);
      // reset in the middle of ITER discards the operation
      issue(32'h40400000, 32'h40400000);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_product", product, 32'h0);
      exp_q.delete();
      lat_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) fail_now("midrst_output_produced");
      end
      issue(32'h40400000, 32'h40400000);
      drain();
      bp_mode = 1;
      for (int i = 0; i < 200; i++) issue(rand_op(), rand_op());
      drain();
      bp_mode = 0;
      repeat (3) @(negedge clk);
      if (lat_q.size() != 0) fail_now("latency_queue_not_empty");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
